// File: rtl/spi_flash_sr_locker.sv
// spi_flash_sr_locker
//   Write-protects the bootloader region of the SPI NOR flash. A one-cycle
//   `go` pulse starts the sequence WREN (06h), WRSR (01h + LOCK_DATA), then
//   RDSR (05h) polling until WIP clears. `rdy` is high when the block is idle
//   or finished. `err` flags a poll timeout and stays set until the next
//   accepted `go`.
//
// Ports:
//   clk       in   system clock (12 MHz HFOSC)
//   rst_n     in   async active-low reset
//   go        in   start pulse, accepted in IDLE/DONE/ERR only
//   rdy       out  idle/finished
//   err       out  RDSR poll timeout, sticky
//   spi_mosi  out  flash DI
//   spi_miso  in   flash DO
//   spi_clk   out  SCK, mode 0
//   spi_cs_n  out  flash chip select, active low
module spi_flash_sr_locker #(
    parameter logic [7:0] LOCK_DATA = 8'h1c,
    parameter int         CLK_DIV   = 2,     // clk cycles per SCK half-period (1..15)
    parameter int         CS_GAP    = 4,     // cs_n high cycles between frames (>=2)
    parameter int         POLL_MAX  = 1023   // RDSR polls before timeout (1..65535)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go,
    output logic rdy,
    output logic err,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic spi_clk,
    output logic spi_cs_n
);

    localparam logic [7:0]    CMD_WREN = 8'h06;
    localparam logic [7:0]    CMD_WRSR = 8'h01;
    localparam logic [7:0]    CMD_RDSR = 8'h05;
    localparam int            GW       = $clog2(CS_GAP + 1);
    localparam logic [3:0]    DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
    localparam logic [15:0]   PMAX     = 16'(POLL_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_GAP1, S_WRSR, S_GAP2, S_POLL, S_DONE, S_ERR
    } state_t;

    // Phases within one CS-low frame. SETUP is one SCK half-period of low
    // time after cs_n falls. HOLD is the half-period after the last falling
    // edge, before cs_n rises.
    typedef enum logic [1:0] {
        PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [3:0]    div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_q, byte_d;      // 1 = second byte of a two-byte frame
    logic [7:0]    sh_q, sh_d;          // tx shift register; [7] is on MOSI
    logic [7:0]    rx_q, rx_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   poll_q, poll_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          rdy_q, rdy_d;
    logic          err_q, err_d;

    logic          start;               // open a new frame this cycle
    logic [7:0]    start_cmd;
    logic [7:0]    second;
    logic          last_bit;
    logic          div_last;

    assign div_last = (div_q == DIV_LAST);
    assign last_bit = (bit_q == 3'd7) && ((state_q == S_WREN) || byte_q);
    // During RDSR the second byte is a read byte, so MOSI is held at 0.
    assign second   = (state_q == S_WRSR) ? LOCK_DATA : 8'h00;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        div_d     = div_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        rx_d      = rx_q;
        gap_d     = gap_q;
        poll_d    = poll_q;
        cs_n_d    = cs_n_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        rdy_d     = rdy_q;
        err_d     = err_q;
        start     = 1'b0;
        start_cmd = CMD_WREN;

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (go) begin
                    state_d   = S_WREN;
                    start     = 1'b1;
                    start_cmd = CMD_WREN;
                    rdy_d     = 1'b0;
                    err_d     = 1'b0;
                    poll_d    = '0;
                end
            end
            S_GAP1: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d   = S_WRSR;
                    start     = 1'b1;
                    start_cmd = CMD_WRSR;
                end
            end
            S_GAP2: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) begin
                    state_d   = S_POLL;
                    start     = 1'b1;
                    start_cmd = CMD_RDSR;
                    poll_d    = poll_q + 16'd1;
                end
            end
            S_WREN, S_WRSR, S_POLL: begin
                div_d = div_q + 4'd1;
                if (div_last) begin
                    div_d = '0;
                    unique case (phase_q)
                        PH_SETUP: phase_d = PH_LOW;
                        PH_LOW: begin
                            // SCK rises on this edge, so MISO is sampled here.
                            phase_d = PH_HIGH;
                            sck_d   = 1'b1;
                            rx_d    = {rx_q[6:0], spi_miso};
                        end
                        PH_HIGH: begin
                            sck_d = 1'b0;
                            bit_d = bit_q + 3'd1;
                            if (last_bit) begin
                                phase_d = PH_HOLD;
                                mosi_d  = 1'b0;
                            end else begin
                                phase_d = PH_LOW;
                                if (bit_q == 3'd7) begin
                                    byte_d = 1'b1;
                                    sh_d   = second;
                                    mosi_d = second[7];
                                end else begin
                                    sh_d   = {sh_q[6:0], 1'b0};
                                    mosi_d = sh_q[6];
                                end
                            end
                        end
                        PH_HOLD: begin
                            cs_n_d = 1'b1;
                            gap_d  = '0;
                            if (state_q == S_WREN) begin
                                state_d = S_GAP1;
                            end else if (state_q == S_WRSR) begin
                                state_d = S_GAP2;
                            end else if (!rx_q[0]) begin
                                state_d = S_DONE;
                                rdy_d   = 1'b1;
                            end else if (poll_q == PMAX) begin
                                // poll_q counts polls already issued, so the
                                // limit is checked before any further increment.
                                state_d = S_ERR;
                                rdy_d   = 1'b1;
                                err_d   = 1'b1;
                            end else begin
                                state_d = S_GAP2;
                            end
                        end
                        default: phase_d = PH_SETUP;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            cs_n_d  = 1'b0;
            sck_d   = 1'b0;
            sh_d    = start_cmd;
            mosi_d  = start_cmd[7];
            phase_d = PH_SETUP;
            div_d   = '0;
            bit_d   = '0;
            byte_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= PH_SETUP;
            div_q   <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            gap_q   <= '0;
            poll_q  <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            rdy_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            rx_q    <= rx_d;
            gap_q   <= gap_d;
            poll_q  <= poll_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
        end
    end

    assign rdy      = rdy_q;
    assign err      = err_q;
    assign spi_mosi = mosi_q;
    assign spi_clk  = sck_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_flash_sr_locker.sv
// Bench for spi_flash_sr_locker. Three instances share one clock:
//   u_dut0  default parameters
//   u_dut1  POLL_MAX=4
//   u_dut2  CLK_DIV=1, LOCK_DATA=A5h
// A shared monitor decodes each SPI bus into frames and also acts as the
// flash, driving a programmable status register on MISO.
module tb_spi_flash_sr_locker;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst_n_s, go_s, miso_s;
    logic [NI-1:0] rdy_s, err_s, mosi_s, sck_s, cs_s;

    spi_flash_sr_locker u_dut0 (
        .clk(clk), .rst_n(rst_n_s[0]), .go(go_s[0]), .rdy(rdy_s[0]), .err(err_s[0]),
        .spi_mosi(mosi_s[0]), .spi_miso(miso_s[0]), .spi_clk(sck_s[0]), .spi_cs_n(cs_s[0]));
    spi_flash_sr_locker #(.POLL_MAX(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n_s[1]), .go(go_s[1]), .rdy(rdy_s[1]), .err(err_s[1]),
        .spi_mosi(mosi_s[1]), .spi_miso(miso_s[1]), .spi_clk(sck_s[1]), .spi_cs_n(cs_s[1]));
    spi_flash_sr_locker #(.CLK_DIV(1), .LOCK_DATA(8'hA5)) u_dut2 (
        .clk(clk), .rst_n(rst_n_s[2]), .go(go_s[2]), .rdy(rdy_s[2]), .err(err_s[2]),
        .spi_mosi(mosi_s[2]), .spi_miso(miso_s[2]), .spi_clk(sck_s[2]), .spi_cs_n(cs_s[2]));

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction
    function automatic logic [7:0] lock_of(input int i);
        return (i == 2) ? 8'hA5 : 8'h1C;
    endfunction

    // Flash model controls, written by the stimulus.
    int         busy_polls [NI];
    int         poll_base  [NI];
    logic [7:0] sr_busy    [NI];
    logic [7:0] sr_idle    [NI];

    // Monitor state, written only by the monitor.
    int          fcnt [NI], polls_seen [NI], nrise [NI], nedge [NI];
    int          run_len [NI], cs_lo_len [NI], cs_hi_len [NI];
    int          hi_min [NI], hi_max [NI], lo_min [NI], gap_min [NI];
    bit          prev_sck [NI];
    logic [15:0] fdata [NI];
    logic [15:0] f_data [NI][32];
    int          f_nb [NI][32];
    int          f_len [NI][32];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [7:0] sr;
            if (cs_s[i] === 1'b0) begin
                if (cs_lo_len[i] == 0) begin
                    if (cs_hi_len[i] > 0 && (gap_min[i] == 0 || cs_hi_len[i] < gap_min[i]))
                        gap_min[i] = cs_hi_len[i];
                    cs_hi_len[i] = 0;
                    nrise[i] = 0;
                    nedge[i] = 0;
                    fdata[i] = '0;
                    run_len[i] = 0;
                end
                cs_lo_len[i]++;
                if (cs_lo_len[i] > 1 && sck_s[i] != prev_sck[i]) begin
                    nedge[i]++;
                    if (sck_s[i]) begin
                        if (lo_min[i] == 0 || run_len[i] < lo_min[i]) lo_min[i] = run_len[i];
                        fdata[i] = {fdata[i][14:0], mosi_s[i]};
                        nrise[i]++;
                    end else begin
                        if (hi_min[i] == 0 || run_len[i] < hi_min[i]) hi_min[i] = run_len[i];
                        if (run_len[i] > hi_max[i]) hi_max[i] = run_len[i];
                    end
                    run_len[i] = 1;
                end else begin
                    run_len[i]++;
                end
            end else begin
                if (cs_lo_len[i] > 0) begin
                    if (fcnt[i] < 32) begin
                        f_data[i][fcnt[i]] = fdata[i];
                        f_nb[i][fcnt[i]]   = nrise[i];
                        f_len[i][fcnt[i]]  = cs_lo_len[i];
                    end
                    if (nrise[i] == 16 && fdata[i][15:8] == 8'h05) polls_seen[i]++;
                    fcnt[i]++;
                end
                cs_lo_len[i] = 0;
                cs_hi_len[i]++;
            end
            prev_sck[i] = sck_s[i];
            // Flash side: present the next read bit before the next SCK rise.
            sr = ((polls_seen[i] - poll_base[i]) < busy_polls[i]) ? sr_busy[i] : sr_idle[i];
            miso_s[i] = 1'b0;
            if (cs_s[i] === 1'b0 && nrise[i] >= 8 && nrise[i] < 16)
                miso_s[i] = sr[15 - nrise[i]];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_go(input int i, input int id);
        go_s[i] = 1'b1;
        tick();
        go_s[i] = 1'b0;
        check($sformatf("v%0d_rdy_low", id), rdy_s[i], 1'b0);
        check($sformatf("v%0d_err_clr", id), err_s[i], 1'b0);
    endtask

    typedef struct {
        int         inst;
        int         busy;
        logic [7:0] sr_busy;
        logic [7:0] sr_idle;
        bit         mid_go;
        int         exp_polls;
        bit         exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v, input int id);
        int i;
        int base;
        int cyc;
        i = v.inst;
        base = fcnt[i];
        poll_base[i]  = polls_seen[i];
        busy_polls[i] = v.busy;
        sr_busy[i]    = v.sr_busy;
        sr_idle[i]    = v.sr_idle;
        pulse_go(i, id);
        if (v.mid_go) begin
            cyc = 0;
            while (!(fcnt[i] == base + 1 && cs_s[i] == 1'b0) && cyc < 5000) begin
                tick();
                cyc++;
            end
            check($sformatf("v%0d_wrsr_wait", id), cyc < 5000, 1'b1);
            repeat (6) tick();
            go_s[i] = 1'b1;
            tick();
            go_s[i] = 1'b0;
        end
        cyc = 0;
        while (rdy_s[i] !== 1'b1 && cyc < 20000) begin
            tick();
            cyc++;
        end
        check($sformatf("v%0d_done_wait", id), cyc < 20000, 1'b1);
        check($sformatf("v%0d_err", id), err_s[i], v.exp_err);
        check($sformatf("v%0d_frames", id), fcnt[i] - base, 2 + v.exp_polls);
        check($sformatf("v%0d_idle_bus", id), {cs_s[i], sck_s[i], mosi_s[i]}, 3'b100);
        if (base + 2 + v.exp_polls <= 32) begin
            check($sformatf("v%0d_wren_nb", id), f_nb[i][base], 8);
            check($sformatf("v%0d_wren", id), f_data[i][base][7:0], 8'h06);
            check($sformatf("v%0d_wren_len", id), f_len[i][base], 18 * div_of(i));
            check($sformatf("v%0d_wrsr_nb", id), f_nb[i][base+1], 16);
            check($sformatf("v%0d_wrsr", id), f_data[i][base+1], {8'h01, lock_of(i)});
            check($sformatf("v%0d_wrsr_len", id), f_len[i][base+1], 34 * div_of(i));
            for (int k = 0; k < v.exp_polls; k++) begin
                check($sformatf("v%0d_rdsr%0d_nb", id, k), f_nb[i][base+2+k], 16);
                check($sformatf("v%0d_rdsr%0d", id, k), f_data[i][base+2+k], 16'h0500);
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   base;
        int   cyc;
        int   cs_low_seen;

        vecs[0] = '{inst:0, busy:0,   sr_busy:8'h01, sr_idle:8'h00, mid_go:0, exp_polls:1, exp_err:0};
        vecs[1] = '{inst:0, busy:3,   sr_busy:8'h01, sr_idle:8'h00, mid_go:0, exp_polls:4, exp_err:0};
        vecs[2] = '{inst:1, busy:100, sr_busy:8'h03, sr_idle:8'h00, mid_go:0, exp_polls:4, exp_err:1};
        vecs[3] = '{inst:1, busy:0,   sr_busy:8'h01, sr_idle:8'h00, mid_go:0, exp_polls:1, exp_err:0};
        vecs[4] = '{inst:0, busy:0,   sr_busy:8'h01, sr_idle:8'h00, mid_go:1, exp_polls:1, exp_err:0};
        vecs[5] = '{inst:0, busy:0,   sr_busy:8'h01, sr_idle:8'h00, mid_go:0, exp_polls:1, exp_err:0};
        // bit0 busy, bit7 set when idle: only a correct WIP bit ends after 2 polls
        vecs[6] = '{inst:2, busy:1,   sr_busy:8'h01, sr_idle:8'hFE, mid_go:0, exp_polls:2, exp_err:0};

        for (int i = 0; i < NI; i++) begin
            busy_polls[i] = 0;
            poll_base[i]  = 0;
            sr_busy[i]    = 8'h01;
            sr_idle[i]    = 8'h00;
        end
        rst_n_s = '0;
        go_s    = '0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("reset_outs%0d", i),
                  {rdy_s[i], err_s[i], cs_s[i], sck_s[i], mosi_s[i]}, 5'b10100);
        rst_n_s = '1;
        repeat (5) tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("post_reset_idle%0d", i),
                  {rdy_s[i], err_s[i], cs_s[i], sck_s[i]}, 4'b1010);

        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v], v);
            repeat (10) tick();
        end

        // Reset in the middle of the WRSR frame.
        base = fcnt[0];
        busy_polls[0] = 0;
        poll_base[0]  = polls_seen[0];
        pulse_go(0, 7);
        cyc = 0;
        while (!(fcnt[0] == base + 1 && cs_s[0] == 1'b0 && nedge[0] >= 10) && cyc < 5000) begin
            tick();
            cyc++;
        end
        check("rst_mid_wait", cyc < 5000, 1'b1);
        rst_n_s[0] = 1'b0;
        #1;
        check("rst_mid_cs", cs_s[0], 1'b1);
        check("rst_mid_sck", sck_s[0], 1'b0);
        check("rst_mid_rdy", rdy_s[0], 1'b1);
        check("rst_mid_mosi_err", {mosi_s[0], err_s[0]}, 2'b00);
        repeat (3) tick();
        rst_n_s[0] = 1'b1;
        cs_low_seen = 0;
        repeat (40) begin
            tick();
            if (cs_s[0] !== 1'b1) cs_low_seen++;
        end
        check("rst_no_activity", cs_low_seen, 0);
        check("rst_idle_rdy", rdy_s[0], 1'b1);
        check("rst_frames", fcnt[0] - base, 2);
        check("rst_wrsr_partial", f_nb[0][base+1] < 16, 1'b1);
        run_vec(vecs[0], 8);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("sck_hi_min%0d", i), hi_min[i], div_of(i));
            check($sformatf("sck_hi_max%0d", i), hi_max[i], div_of(i));
            check($sformatf("sck_lo_min%0d", i), lo_min[i], div_of(i));
            check($sformatf("cs_gap%0d", i), gap_min[i] >= 4, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
